rr_token_arbiter: RTL and testbench
===================================

Name: rr_token_arbiter

Overview:
- Round-robin arbiter that shares one resource among 16 requesters using a rotating one-hot priority token, the ring-counter scheme used elsewhere in the datapath.
- Issues a one-hot grant plus a 4-bit encoded grant index.
- Holds the grant until the owner signals DONE or drops its request, then advances the token past the last owner.
- Sits between the requester bank and the shared resource's select/mux logic.

Parameters:
- N, 16, number of requesters; fixed at 16 in this revision.
- IDW, 4, width of the encoded grant index (log2 N).
- MAX_HOLD, 8, cycles a grant may be held before forced release; used only with ARB_TIMEOUT_EN; legal range 1..255.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous, active-high reset.
- REQ  input  [0:15]  request per requester; bit i = requester i.
- DONE  input  1  current owner releases the resource this cycle.
- GNT  output  [0:15]  one-hot grant; all zero when no grant is active.
- GNT_ID  output  [3:0]  encoded index of the GNT bit; 0 when GNT_VLD=0.
- GNT_VLD  output  1  a grant is active.
- TIMEOUT  output  1  one-cycle pulse on forced release; constant 0 without ARB_TIMEOUT_EN.

Behaviour:
- All outputs are registered.
- Reset (sync, RST=1 at a CLK edge):
  - state=IDLE; PTR=one-hot bit 0; GNT=0; GNT_ID=0; GNT_VLD=0; TIMEOUT=0; hold counter=0.
  - RST asserted mid-grant drops the grant at that edge with no DONE required; PTR returns to bit 0.
- State IDLE:
  - If REQ!=0: select the first set REQ bit scanning upward from the PTR position, wrapping 15->0 (PTR position included).
  - At the next edge: GNT=that bit, GNT_ID=its index, GNT_VLD=1, state=GRANT.
  - Latency is 1 cycle from REQ sampled to GNT valid.
  - If REQ==0: stay in IDLE; outputs stay 0.
  - DONE is ignored in IDLE.
- State GRANT:
  - GNT and GNT_ID are held stable; REQ changes on other bits have no effect.
  - Release condition: DONE=1, or REQ[GNT_ID]=0. Both together count as one release.
  - At the release edge: GNT=0, GNT_VLD=0, GNT_ID=0, PTR=GNT rotated by one (bit i -> bit i+1, bit 15 -> bit 0), state=IDLE.
- Minimum gap between consecutive grants is exactly one IDLE cycle with GNT_VLD=0.
- Fairness: a continuously requesting requester is granted within 15 intervening grants.
- Invariants: GNT is always zero or exactly one-hot; PTR is always exactly one-hot.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- When defined:
  - An 8-bit hold counter clears on grant entry and increments each GRANT cycle.
  - If the counter reaches MAX_HOLD-1 without a release condition, the next edge performs a normal release (PTR rotates) and TIMEOUT=1 for one cycle.
  - A release condition in the same cycle wins: normal release, TIMEOUT=0.
- When not defined: no counter is built; TIMEOUT is tied 0; a grant is held indefinitely.

Decomposition:
- Shared package: N, IDW, state encoding (IDLE=1'b0, GRANT=1'b1), and the PTR reset constant (one-hot bit 0).
- Sub-module arb_onehot_enc: combinational 16-to-4 one-hot OR-encoder producing GNT_ID from the next-grant vector.
- Arbitration scan and FSM stay in the top module.

Test Plan:
- Reset, then REQ=0 for 5 cycles -> GNT=0, GNT_VLD=0, GNT_ID=0 throughout.
- REQ=bit3 only at cycle 2 -> cycle 3: GNT=bit3, GNT_ID=3; DONE at cycle 5 -> cycle 6: GNT=0; PTR=bit4.
- REQ=all 16 bits held, DONE pulsed 1 cycle after each grant -> GNT_ID sequence 0,1,2,…,15,0 with one idle cycle between grants.
- PTR=bit14 (after a grant to 13), REQ=bits 2 and 15 -> grant 15; after release PTR=bit0 -> grant 2.
- While granted to 5, drop REQ[5] with DONE=0 -> release at next edge; PTR=bit6. Separately, RST=1 mid-grant -> all outputs 0 at that edge.
- ARB_TIMEOUT_EN with MAX_HOLD=4, grant to 7 with no DONE -> forced release 4 cycles after grant; TIMEOUT=1 for one cycle; next grant searches from 8. Same stimulus without the macro -> grant held, TIMEOUT=0.

Source files
------------

// File: rtl/rr_token_arbiter_pkg.sv
// Shared types and constants for the 16-way round-robin token arbiter.
package rr_token_arbiter_pkg;

    localparam int unsigned N   = 16;
    localparam int unsigned IDW = 4;

    typedef enum logic {
        StIdle  = 1'b0,
        StGrant = 1'b1
    } state_e;

    // Token starts on requester 0 (index 0 is the leftmost bit of a [0:N-1] vector).
    localparam logic [0:N-1] PTR_RST = {1'b1, {(N - 1){1'b0}}};

    // Move a one-hot token from bit i to bit i+1, wrapping N-1 back to 0.
    function automatic logic [0:N-1] rotate_up(input logic [0:N-1] v);
        return {v[N-1], v[0:N-2]};
    endfunction

endpackage

// File: rtl/rr_token_arbiter_if.sv
// Request/grant bundle between the requester bank and the arbiter.
interface rr_token_arbiter_if;
    import rr_token_arbiter_pkg::*;

    logic [0:N-1]   REQ;
    logic           DONE;
    logic [0:N-1]   GNT;
    logic [IDW-1:0] GNT_ID;
    logic           GNT_VLD;
    logic           TIMEOUT;

    // master: arbiter side; slave: requester / resource side.
    modport master (
        input  REQ,
        input  DONE,
        output GNT,
        output GNT_ID,
        output GNT_VLD,
        output TIMEOUT
    );

    modport slave (
        output REQ,
        output DONE,
        input  GNT,
        input  GNT_ID,
        input  GNT_VLD,
        input  TIMEOUT
    );

endinterface

// File: rtl/arb_onehot_enc.sv
// Combinational one-hot to binary OR-encoder.
module arb_onehot_enc
    import rr_token_arbiter_pkg::*;
(
    input  logic [0:N-1]   onehot,
    output logic [IDW-1:0] idx
);

    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (onehot[i]) begin
                idx = idx | IDW'(i);
            end
        end
    end

endmodule

// File: rtl/rr_token_arbiter.sv
// Round-robin arbiter with a rotating one-hot priority token and held grants.
// Optional forced release after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
module rr_token_arbiter
    import rr_token_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic               CLK,
    input  logic               RST,
    rr_token_arbiter_if.master bus
);

    state_e         state_q, state_d;
    logic [0:N-1]   ptr_q, ptr_d;
    logic [0:N-1]   gnt_q, gnt_d;
    logic [IDW-1:0] gnt_id_q, gnt_id_d;
    logic           vld_q, vld_d;
    logic           timeout_q, timeout_d;

    logic [0:N-1]   req;
    logic [IDW-1:0] ptr_idx;
    logic [0:N-1]   next_gnt;
    logic [IDW-1:0] next_id;
    logic           release_req;

    assign req = bus.REQ;

    arb_onehot_enc u_ptr_enc (
        .onehot (ptr_q),
        .idx    (ptr_idx)
    );

    arb_onehot_enc u_gnt_enc (
        .onehot (next_gnt),
        .idx    (next_id)
    );

    // Walk downward from the farthest offset so the nearest requester at or after the token wins.
    always_comb begin
        logic [IDW-1:0] cand;
        cand     = '0;
        next_gnt = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = ptr_idx + IDW'(k);
            if (req[cand]) begin
                next_gnt       = '0;
                next_gnt[cand] = 1'b1;
            end
        end
    end

    assign release_req = bus.DONE || !(|(req & gnt_q));

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_q, hold_d;
    logic       hold_expired;

    assign hold_expired = (hold_q == 8'(MAX_HOLD - 1));
`else
    logic unused_max_hold;
    assign unused_max_hold = (MAX_HOLD != 0);
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        vld_d     = vld_q;
        timeout_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
        hold_d    = '0;
`endif
        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    gnt_d    = next_gnt;
                    gnt_id_d = next_id;
                    vld_d    = 1'b1;
                    state_d  = StGrant;
                end
            end
            StGrant: begin
`ifdef ARB_TIMEOUT_EN
                if (release_req || hold_expired) begin
                    timeout_d = !release_req;
`else
                if (release_req) begin
`endif
                    gnt_d    = '0;
                    gnt_id_d = '0;
                    vld_d    = 1'b0;
                    ptr_d    = rotate_up(gnt_q);
                    state_d  = StIdle;
                end
`ifdef ARB_TIMEOUT_EN
                else begin
                    hold_d = hold_q + 8'd1;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StIdle;
            ptr_q     <= PTR_RST;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            vld_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            vld_q     <= vld_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`endif

    assign bus.GNT     = gnt_q;
    assign bus.GNT_ID  = gnt_id_q;
    assign bus.GNT_VLD = vld_q;
    assign bus.TIMEOUT = timeout_q;

endmodule

// File: tb/tb_rr_token_arbiter.sv
// Self-checking bench for rr_token_arbiter: directed vector table plus randomized model compare.
module tb_rr_token_arbiter;
    import rr_token_arbiter_pkg::*;

    localparam int HOLD = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic CLK;
    logic RST;

    rr_token_arbiter_if bus ();

    rr_token_arbiter #(
        .MAX_HOLD (HOLD)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int checks = 0;
    int errors = 0;

    // Reference model: owner index (-1 = none), token index, cycles owned, timeout pulse.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_held  = 0;
    bit m_to    = 1'b0;

    typedef struct {
        logic        rst;
        logic [0:15] req;
        logic        done;
        int          gid;
        logic        to;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [0:15] onehot(input int i);
        logic [0:15] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [0:15] bits2(input int a, input int b);
        return onehot(a) | onehot(b);
    endfunction

    function automatic logic [21:0] expect_of(input int gid, input logic to);
        logic [3:0] id;
        id = (gid < 0) ? 4'd0 : 4'(gid);
        return {onehot(gid), id, gid >= 0, to};
    endfunction

    function automatic void add(input logic rst, input logic [0:15] req, input logic done,
                                input int gid, input logic to);
        vec_t v;
        v.rst = rst; v.req = req; v.done = done; v.gid = gid; v.to = to;
        tbl.push_back(v);
    endfunction

    task automatic model_step(input logic rst, input logic [0:15] req, input logic done);
        bit rel;
        m_to = 1'b0;
        if (rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_held  = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < 16; k++) begin
                if (m_owner < 0 && req[(m_ptr + k) % 16]) begin
                    m_owner = (m_ptr + k) % 16;
                    m_held  = 1;
                end
            end
        end else begin
            rel = done || !req[m_owner];
            if (rel || (TO_EN && m_held >= HOLD)) begin
                m_to    = !rel;
                m_ptr   = (m_owner + 1) % 16;
                m_owner = -1;
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic check(input string name, input logic [21:0] exp);
        logic [21:0] act;
        act = {bus.GNT, bus.GNT_ID, bus.GNT_VLD, bus.TIMEOUT};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got gnt=%h id=%0d vld=%b to=%b, expected gnt=%h id=%0d vld=%b to=%b",
                     name, $time, act[21:6], act[5:2], act[1], act[0],
                     exp[21:6], exp[5:2], exp[1], exp[0]);
        end
    endtask

    task automatic apply(input logic rst, input logic [0:15] req, input logic done);
        RST      = rst;
        bus.REQ  = req;
        bus.DONE = done;
        @(posedge CLK);
        model_step(rst, req, done);
        #1;
        check("model", expect_of(m_owner, m_to));
    endtask

    initial begin
        logic [0:15] r;
        logic [0:15] all_req;
        all_req  = '1;
        RST      = 1'b1;
        bus.REQ  = '0;
        bus.DONE = 1'b0;

        // rst, req, done, expected grant index (-1 none), expected timeout
        add(1, '0, 0, -1, 0);
        for (int i = 0; i < 5; i++) add(0, '0, 0, -1, 0);
        add(0, onehot(3), 0, 3, 0);
        add(0, onehot(3), 0, 3, 0);
        add(0, onehot(3), 1, -1, 0);
        add(0, '0, 1, -1, 0);                 // DONE ignored while idle
        add(0, onehot(13), 0, 13, 0);         // token at 4 -> 13
        add(0, onehot(13), 1, -1, 0);         // token -> 14
        add(0, bits2(2, 15), 0, 15, 0);
        add(0, bits2(2, 15), 1, -1, 0);       // token wraps to 0
        add(0, bits2(2, 15), 0, 2, 0);
        add(0, bits2(2, 15), 1, -1, 0);
        add(0, onehot(5), 0, 5, 0);
        add(0, '0, 0, -1, 0);                 // request dropped -> release, token 6
        add(0, bits2(5, 6), 0, 6, 0);
        add(0, bits2(5, 6) | onehot(1), 0, 6, 0);
        add(1, bits2(5, 6), 0, -1, 0);        // reset mid-grant
        add(0, bits2(5, 6), 0, 5, 0);
        add(0, bits2(5, 6), 1, -1, 0);
        add(0, '0, 0, -1, 0);
        add(0, bits2(7, 9), 0, 7, 0);
        add(0, bits2(7, 9), 0, 7, 0);
        add(0, bits2(7, 9), 0, 7, 0);
        add(0, bits2(7, 9), 0, 7, 0);
`ifdef ARB_TIMEOUT_EN
        add(0, bits2(7, 9), 0, -1, 1);        // forced release
        add(0, bits2(7, 9), 0, 9, 0);         // search restarts at 8
        add(0, bits2(7, 9), 1, -1, 0);
`else
        add(0, bits2(7, 9), 0, 7, 0);
        add(0, bits2(7, 9), 0, 7, 0);
        add(0, bits2(7, 9), 1, -1, 0);
`endif

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].rst, tbl[i].req, tbl[i].done);
            check($sformatf("vec%0d", i), expect_of(tbl[i].gid, tbl[i].to));
        end

        // Full rotation: every requester active, one grant per two cycles.
        apply(1, '0, 0);
        for (int g = 0; g <= 16; g++) begin
            apply(0, all_req, 0);
            check($sformatf("rr_grant%0d", g), expect_of(g % 16, 1'b0));
            apply(0, all_req, 1);
            check($sformatf("rr_gap%0d", g), expect_of(-1, 1'b0));
        end

        // Randomized traffic against the model.
        r = '0;
        for (int c = 0; c < 3000; c++) begin
            case ($urandom_range(0, 7))
                0:       r = '0;
                1:       r = onehot(int'($urandom_range(0, 15)));
                2:       r = 16'($urandom);
                3:       r = r ^ onehot(int'($urandom_range(0, 15)));
                default: ;
            endcase
            apply($urandom_range(0, 199) == 0, r, $urandom_range(0, 6) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
